// File: rtl/decode_issue_pkg.sv
// decode_issue_pkg
//   Shared definitions for the LEGv8 decode/issue stage: datapath widths,
//   format class codes, opcode match constants, the zero register, and the
//   combinational instruction classifier used by the decode stage.
//   Optional feature macro used by the decode stage: LEGV8_WB_BYPASS_EN.
package decode_issue_pkg;

    localparam int WORDSIZE    = 64;
    localparam int REGADDRSIZE = 5;

    // Format class codes presented on out_class
    localparam logic [2:0] CLASS_B   = 3'd0;
    localparam logic [2:0] CLASS_CB  = 3'd1;
    localparam logic [2:0] CLASS_D   = 3'd2;
    localparam logic [2:0] CLASS_I   = 3'd3;
    localparam logic [2:0] CLASS_R   = 3'd4;
    localparam logic [2:0] CLASS_ILL = 3'd7;

    // Opcode match constants
    localparam logic [4:0] OP_B_30_26  = 5'b00101;
    localparam logic [6:0] OP_CB_31_25 = 7'b1011010;
    localparam logic [5:0] OP_D_29_24  = 6'b111000;
    localparam logic [3:0] OP_I_28_25  = 4'b1000;
    localparam logic [2:0] OP_R_27_25  = 3'b101;

    localparam logic [REGADDRSIZE-1:0] XZR      = 5'd31;
    localparam logic [REGADDRSIZE-1:0] LINK_REG = 5'd30;

    typedef struct packed {
        logic [2:0]             cls;
        logic                   illegal;
        logic                   use_n;   // Rn is a real source
        logic                   use_m;   // port-m address is a real source
        logic                   wren;    // writes rd (never for XZR)
        logic [REGADDRSIZE-1:0] rn;
        logic [REGADDRSIZE-1:0] rm;      // address driven on port m
        logic [REGADDRSIZE-1:0] rd;
    } decode_t;

    // First match wins, in the order B, CB, D, I, R.
    function automatic decode_t decode(input logic [31:0] instr);
        decode_t d;
        d         = '0;
        d.cls     = CLASS_ILL;
        d.illegal = 1'b1;
        d.rn      = instr[9:5];
        d.rm      = instr[20:16];
        d.rd      = instr[4:0];
        if (instr[30:26] == OP_B_30_26) begin
            d.cls     = CLASS_B;
            d.illegal = 1'b0;
            if (instr[31]) begin
                d.wren = 1'b1;
                d.rd   = LINK_REG;
            end
        end else if (instr[31:25] == OP_CB_31_25) begin
            d.cls     = CLASS_CB;
            d.illegal = 1'b0;
            d.use_m   = 1'b1;
            d.rm      = instr[4:0];
        end else if (instr[29:24] == OP_D_29_24) begin
            d.cls     = CLASS_D;
            d.illegal = 1'b0;
            d.use_n   = 1'b1;
            if (instr[22]) begin
                d.wren = 1'b1;
            end else begin
                // Store data register travels on port m
                d.use_m = 1'b1;
                d.rm    = instr[4:0];
            end
        end else if (instr[28:25] == OP_I_28_25) begin
            d.cls     = CLASS_I;
            d.illegal = 1'b0;
            d.use_n   = 1'b1;
            d.wren    = 1'b1;
        end else if (!instr[28] && (instr[27:25] == OP_R_27_25)) begin
            d.cls     = CLASS_R;
            d.illegal = 1'b0;
            d.use_n   = 1'b1;
            d.use_m   = 1'b1;
            d.wren    = 1'b1;
        end
        // Writes to the zero register are discarded, so they reserve nothing
        if (d.rd == XZR) begin
            d.wren = 1'b0;
        end
        return d;
    endfunction

endpackage

// File: rtl/decode_issue_scoreboard.sv
// decode_issue_scoreboard
//   Busy bitmap of registers with a pending write.
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     set_en/set_idx        reserve a destination at issue
//     clr_en/clr_idx        release on writeback
//     rel_en/rel_idx        release of a squashed entry's destination
//     qn_idx/qn_busy        source query, port n
//     qm_idx/qm_busy        source query, port m
//     qd_idx/qd_busy        destination query (WAW)
module decode_issue_scoreboard
    import decode_issue_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   set_en,
    input  logic [REGADDRSIZE-1:0] set_idx,
    input  logic                   clr_en,
    input  logic [REGADDRSIZE-1:0] clr_idx,
    input  logic                   rel_en,
    input  logic [REGADDRSIZE-1:0] rel_idx,
    input  logic [REGADDRSIZE-1:0] qn_idx,
    input  logic [REGADDRSIZE-1:0] qm_idx,
    input  logic [REGADDRSIZE-1:0] qd_idx,
    output logic                   qn_busy,
    output logic                   qm_busy,
    output logic                   qd_busy
);

    logic [(1<<REGADDRSIZE)-1:0] busy;
    logic [(1<<REGADDRSIZE)-1:0] busy_next;

    // Clears first, then the set, so a same-cycle set of the same bit wins
    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_idx] = 1'b0;
        end
        if (rel_en) begin
            busy_next[rel_idx] = 1'b0;
        end
        if (set_en) begin
            busy_next[set_idx] = 1'b1;
        end
        busy_next[XZR] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign qn_busy = busy[qn_idx];
    assign qm_busy = busy[qm_idx];
    assign qd_busy = busy[qd_idx];

endmodule

// File: rtl/decode_issue.sv
// decode_issue
//   ID stage of the LEGv8 pipeline. Classifies one instruction per cycle,
//   drives the register-file read addresses, tracks pending writes in a
//   scoreboard, and issues into a single ID/EX output register.
//   Ports:
//     clk, reset                       clock, synchronous active-high reset
//     flush                            squash the held ID/EX entry
//     in_valid/in_ready                fetch handshake
//     in_instr, in_pc                  instruction word and address
//     rf_rn, rf_rm                     register-file read addresses
//     rf_outn, rf_outm                 register-file read data
//     wb_valid, wb_rd, wb_data         writeback of the execute/memory side
//     out_valid/out_ready              ID/EX handshake
//     out_instr, out_pc, out_opa,
//     out_opb, out_rd, out_wren,
//     out_class, out_illegal           issued entry
//   Build option: LEGV8_WB_BYPASS_EN forwards wb_data to a source being
//   written back this cycle instead of stalling one extra cycle.
module decode_issue
    import decode_issue_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [WORDSIZE-1:0]    in_pc,
    output logic [REGADDRSIZE-1:0] rf_rn,
    output logic [REGADDRSIZE-1:0] rf_rm,
    input  logic [WORDSIZE-1:0]    rf_outn,
    input  logic [WORDSIZE-1:0]    rf_outm,
    input  logic                   wb_valid,
    input  logic [REGADDRSIZE-1:0] wb_rd,
    input  logic [WORDSIZE-1:0]    wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [WORDSIZE-1:0]    out_pc,
    output logic [WORDSIZE-1:0]    out_opa,
    output logic [WORDSIZE-1:0]    out_opb,
    output logic [REGADDRSIZE-1:0] out_rd,
    output logic                   out_wren,
    output logic [2:0]             out_class,
    output logic                   out_illegal
);

    decode_t             dec;
    logic                n_busy;
    logic                m_busy;
    logic                d_busy;
    logic                hazard;
    logic                issue;
    logic [WORDSIZE-1:0] opa;
    logic [WORDSIZE-1:0] opb;

    assign dec   = decode(in_instr);
    assign rf_rn = dec.rn;
    assign rf_rm = dec.rm;

    decode_issue_scoreboard u_sb (
        .clk     (clk),
        .reset   (reset),
        .set_en  (issue && dec.wren),
        .set_idx (dec.rd),
        .clr_en  (wb_valid),
        .clr_idx (wb_rd),
        .rel_en  (flush && out_valid && out_wren),
        .rel_idx (out_rd),
        .qn_idx  (dec.rn),
        .qm_idx  (dec.rm),
        .qd_idx  (dec.rd),
        .qn_busy (n_busy),
        .qm_busy (m_busy),
        .qd_busy (d_busy)
    );

`ifdef LEGV8_WB_BYPASS_EN
    logic wb_hit_n;
    logic wb_hit_m;
    logic wb_hit_d;

    // A register written back this cycle already holds its final value on
    // wb_data, so it no longer blocks and is forwarded past the regfile.
    assign wb_hit_n = wb_valid && (wb_rd == dec.rn) && (dec.rn != XZR);
    assign wb_hit_m = wb_valid && (wb_rd == dec.rm) && (dec.rm != XZR);
    assign wb_hit_d = wb_valid && (wb_rd == dec.rd);

    assign hazard = (dec.use_n && n_busy && !wb_hit_n) ||
                    (dec.use_m && m_busy && !wb_hit_m) ||
                    (dec.wren  && d_busy && !wb_hit_d);
    assign opa    = wb_hit_n ? wb_data : rf_outn;
    assign opb    = wb_hit_m ? wb_data : rf_outm;
`else
    logic unused_wb_data;

    // The regfile write lands on this edge while its read is still old, so a
    // bit being cleared this cycle keeps blocking for one more cycle.
    assign hazard = (dec.use_n && n_busy) ||
                    (dec.use_m && m_busy) ||
                    (dec.wren  && d_busy);
    assign opa    = rf_outn;
    assign opb    = rf_outm;
    assign unused_wb_data = ^wb_data;
`endif

    assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
    assign issue    = in_valid && in_ready;

    // ID/EX boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
            out_opa     <= '0;
            out_opb     <= '0;
            out_rd      <= '0;
            out_wren    <= 1'b0;
            out_class   <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (issue) begin
            out_valid   <= 1'b1;
            out_instr   <= in_instr;
            out_pc      <= in_pc;
            out_opa     <= opa;
            out_opb     <= opb;
            out_rd      <= dec.rd;
            out_wren    <= dec.wren;
            out_class   <= dec.cls;
            out_illegal <= dec.illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue
//   Randomized and directed stimulus for decode_issue. A reference model
//   predicts handshakes, read addresses and the busy set each cycle and
//   queues the expected issued entry; a monitor checks presented entries.
`timescale 1ns/1ps
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [63:0] in_pc = '0;
    logic [4:0]  rf_rn, rf_rm;
    logic [63:0] rf_outn, rf_outm;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [63:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [63:0] out_pc, out_opa, out_opb;
    logic [4:0]  out_rd;
    logic        out_wren;
    logic [2:0]  out_class;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_issue dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .rf_rn(rf_rn), .rf_rm(rf_rm), .rf_outn(rf_outn), .rf_outm(rf_outm),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_opa(out_opa),
        .out_opb(out_opb), .out_rd(out_rd), .out_wren(out_wren),
        .out_class(out_class), .out_illegal(out_illegal)
    );

    // Environment register file: combinational read, write on the clock edge
    logic [63:0] regs [32];
    assign rf_outn = (rf_rn == 5'd31) ? 64'd0 : regs[rf_rn];
    assign rf_outm = (rf_rm == 5'd31) ? 64'd0 : regs[rf_rm];

    typedef struct packed {
        logic [2:0] cls;
        logic       ill;
        logic       use_n;
        logic       use_m;
        logic       wr;
        logic [4:0] rn;
        logic [4:0] rm;
        logic [4:0] rd;
    } ref_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] opa;
        logic [63:0] opb;
        logic [4:0]  rd;
        logic        wren;
        logic [2:0]  cls;
        logic        ill;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] mbusy = '0;
    logic        exp_valid = 1'b0;
    logic        held_wr = 1'b0;
    logic [4:0]  held_rd = '0;
    logic        post_reset = 1'b1;

    function automatic ref_t ref_decode(input logic [31:0] w);
        ref_t r;
        r    = '0;
        r.rn = w[9:5];
        r.rm = w[20:16];
        r.rd = w[4:0];
        if (w[30:26] == 5'b00101) begin
            r.cls = 3'd0;
            if (w[31]) begin r.wr = 1'b1; r.rd = 5'd30; end
        end else if (w[31:25] == 7'b1011010) begin
            r.cls = 3'd1; r.use_m = 1'b1; r.rm = w[4:0];
        end else if (w[29:24] == 6'b111000) begin
            r.cls = 3'd2; r.use_n = 1'b1;
            if (w[22]) r.wr = 1'b1;
            else begin r.use_m = 1'b1; r.rm = w[4:0]; end
        end else if (w[28:25] == 4'b1000) begin
            r.cls = 3'd3; r.use_n = 1'b1; r.wr = 1'b1;
        end else if (w[28] == 1'b0 && w[27:25] == 3'b101) begin
            r.cls = 3'd4; r.use_n = 1'b1; r.use_m = 1'b1; r.wr = 1'b1;
        end else begin
            r.cls = 3'd7; r.ill = 1'b1;
        end
        if (r.rd == 5'd31) r.wr = 1'b0;
        return r;
    endfunction

    // Value a source register yields when read this cycle
    function automatic logic [63:0] src_val(input logic [4:0] a);
        if (a == 5'd31) return 64'd0;
`ifdef LEGV8_WB_BYPASS_EN
        if (wb_valid && wb_rd == a) return wb_data;
`endif
        return regs[a];
    endfunction

    // Register still blocking this cycle
    function automatic logic pending(input logic [4:0] a);
`ifdef LEGV8_WB_BYPASS_EN
        if (wb_valid && wb_rd == a) return 1'b0;
`endif
        return mbusy[a];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: per-cycle prediction of handshake and busy set
    initial begin : model
        forever begin
            ref_t       d;
            logic       exp_rdy;
            logic       iss;
            logic [31:0] nb;
            exp_t       e;
            @(negedge clk);
            d = ref_decode(in_instr);
            chk("rf_rn", {59'd0, rf_rn}, {59'd0, d.rn});
            chk("rf_rm", {59'd0, rf_rm}, {59'd0, d.rm});
            chk("busy", {32'd0, dut.u_sb.busy}, {32'd0, mbusy});
            chk("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
            if (post_reset && !exp_valid) begin
                chk("reset_data", out_pc | out_opa | out_opb |
                    {32'd0, out_instr} | {59'd0, out_rd} | {61'd0, out_class} |
                    {63'd0, out_wren} | {63'd0, out_illegal}, 64'd0);
            end
            if (reset) begin
                mbusy      = '0;
                exp_valid  = 1'b0;
                held_wr    = 1'b0;
                post_reset = 1'b1;
                expq.delete();
            end else begin
                exp_rdy = !((d.use_n && pending(d.rn)) || (d.use_m && pending(d.rm)) ||
                            (d.wr && pending(d.rd))) &&
                          (!exp_valid || out_ready) && !flush;
                chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
                iss = in_valid && exp_rdy;
                nb  = mbusy;
                if (wb_valid) nb[wb_rd] = 1'b0;
                if (flush && exp_valid && held_wr) nb[held_rd] = 1'b0;
                if (iss && d.wr) nb[d.rd] = 1'b1;
                mbusy = nb;
                if (flush) begin
                    exp_valid = 1'b0;
                end else if (iss) begin
                    e.instr = in_instr;
                    e.pc    = in_pc;
                    e.opa   = src_val(d.rn);
                    e.opb   = src_val(d.rm);
                    e.rd    = d.rd;
                    e.wren  = d.wr;
                    e.cls   = d.cls;
                    e.ill   = d.ill;
                    expq.push_back(e);
                    exp_valid  = 1'b1;
                    held_wr    = d.wr;
                    held_rd    = d.rd;
                    post_reset = 1'b0;
                end else if (out_ready) begin
                    exp_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: compare each presented entry with the queue head
    initial begin : monitor
        forever begin
            exp_t e;
            @(negedge clk);
            if (!reset && out_valid) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_entry actual=%0h required=none", out_instr);
                end else begin
                    e = expq[0];
                    chk("out_instr", {32'd0, out_instr}, {32'd0, e.instr});
                    chk("out_pc", out_pc, e.pc);
                    chk("out_opa", out_opa, e.opa);
                    chk("out_opb", out_opb, e.opb);
                    chk("out_wren", {63'd0, out_wren}, {63'd0, e.wren});
                    chk("out_class", {61'd0, out_class}, {61'd0, e.cls});
                    chk("out_illegal", {63'd0, out_illegal}, {63'd0, e.ill});
                    if (e.wren) chk("out_rd", {59'd0, out_rd}, {59'd0, e.rd});
                    if (flush || out_ready) void'(expq.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic rst, input logic v, input logic [31:0] ins,
                         input logic rdy, input logic fl, input logic wv, input logic [4:0] wr);
        @(posedge clk);
        if (!reset && wb_valid && wb_rd != 5'd31) regs[wb_rd] <= wb_data;
        #1;
        reset     = rst;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = {$urandom, $urandom};
        out_ready = rdy;
        flush     = fl;
        wb_valid  = wv;
        wb_rd     = wr;
        wb_data   = {$urandom, $urandom};
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
        return {11'b10001011000, rm, 6'd0, rn, rd};
    endfunction

    function automatic logic [4:0] rnd_reg();
        return ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        case ($urandom_range(0, 5))
            0: w = {1'($urandom), 5'b00101, 26'($urandom)};
            1: w = {7'b1011010, 1'($urandom), 19'($urandom), rnd_reg()};
            2: w = {2'b11, 6'b111000, 1'b0, 1'($urandom), 1'b0, 9'($urandom), 2'b00, rnd_reg(), rnd_reg()};
            3: w = {10'b1001000100, 12'($urandom), rnd_reg(), rnd_reg()};
            4: w = enc_r(rnd_reg(), rnd_reg(), rnd_reg());
            default: w = $urandom;
        endcase
        return w;
    endfunction

    initial begin : stimulus
        logic [31:0] ldur;
        logic [4:0]  cand[$];
        logic [4:0]  wr;
        logic        wv;
        for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
        regs[2] = 64'd5;
        regs[3] = 64'd7;
        ldur = 32'hF8400024;
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);

        // ADD X1,X2,X3 then dependent LDUR X4,[X1]
        drive(0, 1, 32'h8B030041, 1, 0, 0, 0);
        drive(0, 1, ldur, 1, 0, 0, 0);
        drive(0, 1, ldur, 1, 0, 0, 0);
        drive(0, 1, ldur, 1, 0, 1, 5'd1);
        drive(0, 1, ldur, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        // STUR X9,[X10], CBZ X9, then clear X4
        drive(0, 1, 32'hF8000149, 1, 0, 1, 5'd4);
        drive(0, 1, 32'hB4000009, 1, 0, 0, 0);
        // Writes to and reads of XZR back-to-back
        drive(0, 1, enc_r(5'd31, 5'd1, 5'd2), 1, 0, 0, 0);
        drive(0, 1, enc_r(5'd3, 5'd31, 5'd31), 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 1, 5'd3);
        // Held ADD X5 squashed by flush with out_ready high
        drive(0, 1, enc_r(5'd5, 5'd1, 5'd2), 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, enc_r(5'd6, 5'd1, 5'd2), 1, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        // Illegal word, then a stall cut short by reset
        drive(0, 1, 32'h00000000, 1, 0, 0, 0);
        drive(0, 1, enc_r(5'd6, 5'd1, 5'd2), 1, 0, 0, 0);
        drive(0, 1, enc_r(5'd7, 5'd6, 5'd6), 0, 0, 0, 0);
        drive(0, 1, enc_r(5'd7, 5'd6, 5'd6), 0, 0, 0, 0);
        drive(1, 1, enc_r(5'd7, 5'd6, 5'd6), 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            cand.delete();
            for (int r = 0; r < 31; r++) if (mbusy[r]) cand.push_back(5'(r));
            wv = 1'b0;
            wr = 5'd0;
            if (cand.size() != 0 && $urandom_range(0, 99) < 40) begin
                wv = 1'b1;
                wr = cand[$urandom_range(0, cand.size() - 1)];
            end else if ($urandom_range(0, 99) < 8) begin
                wv = 1'b1;
                wr = 5'($urandom_range(0, 30));
            end
            drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), rnd_instr(),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0), wv, wr);
        end
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- ID stage of the LEGv8 pipeline, between fetch and execute.
- Accepts one 32-bit instruction per cycle and classifies its format.
- Drives the register-file read addresses and holds a scoreboard of registers with pending writes.
- Issues instruction, operands and write intent into a single ID/EX output register.

Parameters:
WORDSIZE, 64 (from bus.vh), datapath width
REGADDRSIZE, 5 (from bus.vh), register address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  squash held ID/EX entry
in_valid  in  1  fetch has instruction
in_ready  out  1  decode accepts this cycle
in_instr  in  32  instruction word
in_pc  in  WORDSIZE  instruction address
rf_rn  out  REGADDRSIZE  regfile read address n
rf_rm  out  REGADDRSIZE  regfile read address m
rf_outn  in  WORDSIZE  regfile data n
rf_outm  in  WORDSIZE  regfile data m
wb_valid  in  1  writeback completes this cycle
wb_rd  in  REGADDRSIZE  writeback register
wb_data  in  WORDSIZE  writeback data (used only with bypass)
out_valid  out  1  ID/EX entry valid
out_ready  in  1  execute consumes entry
out_instr  out  32  issued instruction
out_pc  out  WORDSIZE  issued address
out_opa  out  WORDSIZE  operand from Rn
out_opb  out  WORDSIZE  operand from port m
out_rd  out  REGADDRSIZE  destination
out_wren  out  1  instruction writes a register
out_class  out  3  format code
out_illegal  out  1  unrecognised encoding

Behaviour:
- Classification, combinational on in_instr, first match wins:
  - B: [30:26]=00101. No reads. BL ([31]=1) writes X30.
  - CB: [31:25]=1011010. Reads Rt [4:0] on port m. No write.
  - D: [29:24]=111000. Reads Rn [9:5].
    - Load ([22]=1) writes Rt [4:0].
    - Store ([22]=0) reads Rt on port m.
  - I: [28:25]=1000. Reads Rn, writes Rd [4:0].
  - R: [28]=0 and [27:25]=101. Reads Rn and Rm [20:16], writes Rd.
  - Else illegal: no reads, no write.
- Read addresses: rf_rn=[9:5]. rf_rm=[4:0] for CB/store, else [20:16].
- Register 31 (XZR): never busy, never reserved. A write to 31 gives out_wren=0.
- Scoreboard: 32 busy bits.
  - Set bit rd at issue when out_wren=1.
  - Clear bit wb_rd on wb_valid.
  - Set and clear of the same bit in one cycle: set wins.
- Hazard: any used source is busy, or destination is busy (WAW). A busy bit being cleared this cycle still counts as busy, because the regfile write lands on the same edge and its combinational read returns the old value.
- in_ready = !hazard && (!out_valid || out_ready) && !flush.
- Issue on in_valid && in_ready. Operands are captured from rf_outn/rf_outm. Latency is 1 cycle to out_valid.
- Output register:
  - Holds stable while out_valid && !out_ready.
  - Clears out_valid on consume without a new issue.
- Illegal instructions still issue, with out_illegal=1 and out_wren=0.
- Flush:
  - Clears out_valid and releases the held entry's busy bit.
  - Blocks issue that cycle.
  - Flush with out_ready in the same cycle: the entry is treated as not consumed.
  - A wb_valid clear in the same cycle still applies.
- Reset:
  - out_valid=0, all busy bits 0.
  - out_instr, out_pc, out_opa, out_opb, out_rd, out_class = 0; out_wren=0; out_illegal=0.
  - Reset mid-stall drops everything.

Optional Feature:
LEGV8_WB_BYPASS_EN
- Defined:
  - A source whose busy bit is cleared by wb_valid this cycle is not a hazard; its operand is taken from wb_data.
  - WAW on that register is also released, and set wins.
- Undefined: that case stalls one extra cycle. wb_data is unused.

Decomposition:
- Shared header bus.vh holds:
  - WORDSIZE and REGADDRSIZE.
  - Class codes: B=0, CB=1, D=2, I=3, R=4, ILL=7.
  - Opcode match constants.
  - XZR=31.
- One sub-module: scoreboard (busy bitmap, set/clear ports, two source-query ports and one destination-query port).

Test Plan:
1. ADD X1,X2,X3 (0x8B030041) with X2=5, X3=7, out_ready=1 -> next cycle out_valid=1, opa=5, opb=7, out_rd=1, out_wren=1, class=4; busy[1]=1.
2. LDUR X4,[X1,#0] immediately after test 1, no writeback -> in_ready=0. Pulse wb_valid, wb_rd=1:
   - Without bypass: issues the cycle after the pulse.
   - With bypass: issues in the pulse cycle with opa=wb_data.
3. STUR X9,[X10] (0xF8000149) -> rf_rm=9, rf_rn=10, out_wren=0, busy unchanged. CBZ X9 reads rf_rm=9.
4. ADD X31,X1,X2 then ADD X3,X31,X31 back-to-back -> both issue without stall; busy[31] stays 0.
5. out_ready=0 with a held ADD X5; assert flush -> out_valid=0 next cycle, busy[5]=0. in_ready=0 during the flush cycle.
6. Word 0x00000000 -> out_illegal=1, class=7, out_wren=0. Reset asserted while stalled -> out_valid=0 and all busy bits 0 next cycle.
